// File: rtl/tile_pattern_generator_if.sv
// Video timing, palette ROM bus and colour outputs of the tile pattern generator.
// The generator side (master) drives the palette address and the colour outputs.
interface tile_pattern_generator_if;
    logic        IAA;
    logic        VS;
    logic [10:0] HCNT;
    logic [10:0] VCNT;
    logic [7:0]  pal_addr;
    logic [23:0] pal_data;
    logic [7:0]  R;
    logic [7:0]  G;
    logic [7:0]  B;
    logic        de_out;

    modport master (
        input  IAA, VS, HCNT, VCNT, pal_data,
        output pal_addr, R, G, B, de_out
    );

    modport slave (
        output IAA, VS, HCNT, VCNT, pal_data,
        input  pal_addr, R, G, B, de_out
    );
endinterface

// File: rtl/tile_pattern_generator.sv
// Tiled VGA test-pattern source: counter-based tile tracking, pattern/scroll palette index,
// external palette ROM lookup and a latency-matched colour and data-enable output stage.
module tile_pattern_generator #(
    parameter int          H_VISIBLE   = 640,
    parameter int          V_VISIBLE   = 480,
    parameter int          TILES_X     = 8,
    parameter int          TILES_Y     = 8,
    parameter int          NUM_COLORS  = 8,
    parameter int          PAL_BASE    = 0,
    parameter int          PAL_LATENCY = 1,
    parameter int          SCROLL_DIV  = 30,
    parameter logic [23:0] OFF_RGB     = 24'h0
) (
    input  logic                     VGA_CLK,
    input  logic                     rst,
    tile_pattern_generator_if.master vga,
    input  logic [1:0]               mode,
    input  logic                     scroll_en
);
    localparam int TILE_W = H_VISIBLE / TILES_X;
    localparam int TILE_H = V_VISIBLE / TILES_Y;
    localparam int PX_W   = $clog2(H_VISIBLE + 1);
    localparam int PY_W   = $clog2(V_VISIBLE + 1);
    localparam int TX_W   = $clog2(TILES_X + 1);
    localparam int TY_W   = $clog2(TILES_Y + 1);
    localparam int OFF_W  = $clog2(NUM_COLORS + 1);
    localparam int DIV_W  = $clog2(SCROLL_DIV + 1);
    localparam int IW     = 16;

    localparam logic [PX_W-1:0]  TILE_W_M1 = PX_W'(TILE_W - 1);
    localparam logic [PY_W-1:0]  TILE_H_M1 = PY_W'(TILE_H - 1);
    localparam logic [TX_W-1:0]  TX_LAST   = TX_W'(TILES_X - 1);
    localparam logic [TY_W-1:0]  TY_LAST   = TY_W'(TILES_Y - 1);
    localparam logic [OFF_W-1:0] OFF_LAST  = OFF_W'(NUM_COLORS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCROLL_DIV - 1);
    localparam logic [IW-1:0]    NC        = IW'(NUM_COLORS);
    localparam logic [IW-1:0]    DIAG_BIAS = IW'(NUM_COLORS * TILES_X);

    logic              iaa_q;
    logic              vs_q;
    logic              frame_armed;
    logic [PX_W-1:0]   px;
    logic [PX_W-1:0]   cur_px;
    logic [TX_W-1:0]   tx;
    logic [TX_W-1:0]   cur_tx;
    logic [PY_W-1:0]   py;
    logic [TY_W-1:0]   ty;
    logic [OFF_W-1:0]  offset;
    logic [DIV_W-1:0]  frame_div;
    logic [1:0]        mode_q;
    logic              line_start;
    logic              line_end;
    logic              frame_tick;
    logic [IW-1:0]     raw_index;
    logic [IW-1:0]     index;
    logic [PAL_LATENCY:0] valid_pipe;
    logic [21:0]       unused_cnt;

    // The timing generator's counters are carried for monitoring only.
    assign unused_cnt = {vga.HCNT, vga.VCNT};

    assign line_start = vga.IAA & ~iaa_q;
    assign line_end   = ~vga.IAA & iaa_q;
    assign frame_tick = ~vga.VS & vs_q;

    // The first pixel of a line already belongs to tile column 0.
    assign cur_px = line_start ? '0 : px;
    assign cur_tx = line_start ? '0 : tx;

    // The diagonal bias keeps ty - tx + offset non-negative before the modulo.
    always_comb begin
        raw_index = '0;
        case (mode_q)
            2'd0:    raw_index = IW'(ty) + IW'(offset) + DIAG_BIAS - IW'(cur_tx);
            2'd1:    raw_index = ((IW'(cur_tx) ^ IW'(ty)) & IW'(1)) + IW'(offset);
            2'd2:    raw_index = IW'(ty) + IW'(offset);
            default: raw_index = IW'(cur_tx) + IW'(offset);
        endcase
        index = raw_index % NC;
    end

    // iaa_q resets high so that a reset released mid-line does not fake a line start;
    // frame_armed keeps ty at 0 until the first frame tick after reset.
    always_ff @(posedge VGA_CLK) begin
        if (!rst) begin
            iaa_q       <= 1'b1;
            vs_q        <= 1'b0;
            frame_armed <= 1'b0;
            px          <= '0;
            tx          <= '0;
            py          <= '0;
            ty          <= '0;
            offset      <= '0;
            frame_div   <= '0;
            mode_q      <= 2'd0;
        end else begin
            iaa_q <= vga.IAA;
            vs_q  <= vga.VS;
            if (vga.IAA) begin
                if (cur_px == TILE_W_M1 && cur_tx < TX_LAST) begin
                    px <= '0;
                    tx <= cur_tx + 1'b1;
                end else begin
                    px <= cur_px + 1'b1;
                    tx <= cur_tx;
                end
            end
            if (frame_tick) begin
                px          <= '0;
                tx          <= '0;
                py          <= '0;
                ty          <= '0;
                frame_armed <= 1'b1;
                mode_q      <= mode;
                if (scroll_en) begin
                    if (frame_div == DIV_LAST) begin
                        frame_div <= '0;
                        offset    <= (offset == OFF_LAST) ? '0 : offset + 1'b1;
                    end else begin
                        frame_div <= frame_div + 1'b1;
                    end
                end
            end else if (line_end && frame_armed) begin
                if (py == TILE_H_M1 && ty < TY_LAST) begin
                    py <= '0;
                    ty <= ty + 1'b1;
                end else begin
                    py <= py + 1'b1;
                end
            end
        end
    end

    // valid_pipe[PAL_LATENCY] lines up with pal_data for the same pixel.
    always_ff @(posedge VGA_CLK) begin
        if (!rst) begin
            vga.pal_addr              <= 8'(PAL_BASE);
            valid_pipe                <= '0;
            {vga.R, vga.G, vga.B}     <= OFF_RGB;
            vga.de_out                <= 1'b0;
        end else begin
            if (vga.IAA) begin
                vga.pal_addr <= 8'(IW'(PAL_BASE) + index);
            end
            valid_pipe            <= {valid_pipe[PAL_LATENCY-1:0], vga.IAA};
            vga.de_out            <= valid_pipe[PAL_LATENCY];
            {vga.R, vga.G, vga.B} <= valid_pipe[PAL_LATENCY] ? vga.pal_data : OFF_RGB;
        end
    end
endmodule

// File: tb/tb_tile_pattern_generator.sv
// Directed bench: a scaled 64x48 generator (8x6-pixel tiles, fast scroll) plus a 645-pixel-wide
// instance for the uneven-tile case, each fed by a one-clock palette ROM returning {a,a,a}.
module tb_tile_pattern_generator;
    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic       scroll_en;
    bit         wide;

    int total;
    int bad;

    int cur_x, cur_y;
    bit cur_v, cur_w;
    int hx [3];
    int hy [3];
    bit hv [3];
    bit hw [3];

    logic [23:0] cap  [0:47][0:63];
    logic [23:0] capw [0:644];
    int de_tot [0:47];
    int de_al  [0:47];
    int dew_tot;

    tile_pattern_generator_if vm();
    tile_pattern_generator_if vw();

    tile_pattern_generator #(
        .H_VISIBLE(64), .V_VISIBLE(48), .SCROLL_DIV(2)
    ) dut (
        .VGA_CLK(clk), .rst(rst), .vga(vm), .mode(mode), .scroll_en(scroll_en)
    );

    tile_pattern_generator #(
        .H_VISIBLE(645)
    ) dut_wide (
        .VGA_CLK(clk), .rst(rst), .vga(vw), .mode(mode), .scroll_en(scroll_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) vm.pal_data <= {vm.pal_addr, vm.pal_addr, vm.pal_addr};
    always @(posedge clk) vw.pal_data <= {vw.pal_addr, vw.pal_addr, vw.pal_addr};

    // Each pixel's colour is expected three clocks after it is presented.
    always @(negedge clk) begin
        if (hv[2]) begin
            if (hw[2]) begin
                capw[hx[2]] = {vw.R, vw.G, vw.B};
            end else if (hy[2] < 48 && hx[2] < 64) begin
                cap[hy[2]][hx[2]] = {vm.R, vm.G, vm.B};
                if (vm.de_out) de_al[hy[2]]++;
            end
        end
        if (vm.de_out && hy[2] >= 0 && hy[2] < 48) de_tot[hy[2]]++;
        if (vw.de_out) dew_tot++;
        for (int i = 2; i > 0; i--) begin
            hx[i] = hx[i-1];
            hy[i] = hy[i-1];
            hv[i] = hv[i-1];
            hw[i] = hw[i-1];
        end
        hx[0] = cur_x;
        hy[0] = cur_y;
        hv[0] = cur_v;
        hw[0] = cur_w;
    end

    function automatic logic [23:0] rgb(input logic [7:0] v);
        return {v, v, v};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit iaa, input bit vs, input int x, input int y);
        @(posedge clk);
        #1;
        if (wide) begin
            vw.IAA = iaa; vw.VS = vs; vw.HCNT = 11'(x); vw.VCNT = 11'(y);
        end else begin
            vm.IAA = iaa; vm.VS = vs; vm.HCNT = 11'(x); vm.VCNT = 11'(y);
        end
        cur_x = x; cur_y = y; cur_v = iaa; cur_w = wide;
    endtask

    task automatic runLine(input int y, input int rst_at);
        int hlen;
        hlen = wide ? 645 : 64;
        for (int x = 0; x < hlen; x++) begin
            if (rst_at >= 0 && x == rst_at) checkOutput("addr_before_rst", 32'(vm.pal_addr), 4);
            rst = (rst_at < 0) || (x < rst_at) || (x >= rst_at + 3);
            applyStimulus(1'b1, 1'b1, x, y);
            if (rst_at >= 0 && x == rst_at + 3) begin
                checkOutput("midrst_rgb", {vm.R, vm.G, vm.B}, 0);
                checkOutput("midrst_de", 32'(vm.de_out), 0);
                checkOutput("midrst_addr", 32'(vm.pal_addr), 0);
            end
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 0, y);
    endtask

    task automatic runFrame(input int nlines, input int sw_line, input logic [1:0] sw_mode,
                            input int rst_at);
        applyStimulus(1'b0, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b1, 0, 0);
        applyStimulus(1'b0, 1'b1, 0, 0);
        for (int y = 0; y < nlines; y++) begin
            if (y == sw_line) mode = sw_mode;
            runLine(y, (y == 0) ? rst_at : -1);
        end
    endtask

    initial begin
        int s0, s47, a0, a47;
        total = 0; bad = 0;
        rst = 1'b0; mode = 2'd0; scroll_en = 1'b0; wide = 1'b0;
        vm.IAA = 1'b0; vm.VS = 1'b1; vm.HCNT = '0; vm.VCNT = '0;
        vw.IAA = 1'b0; vw.VS = 1'b1; vw.HCNT = '0; vw.VCNT = '0;
        cur_x = 0; cur_y = 0; cur_v = 1'b0; cur_w = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_R", 32'(vm.R), 0);
        checkOutput("rst_G", 32'(vm.G), 0);
        checkOutput("rst_B", 32'(vm.B), 0);
        checkOutput("rst_de", 32'(vm.de_out), 0);
        checkOutput("rst_addr", 32'(vm.pal_addr), 0);
        rst = 1'b1;

        // Mode 3 line interrupted by a 3-clock reset at x=40.
        mode = 2'd3;
        runFrame(1, -1, 2'd0, 40);

        // Mode 0 diagonal, first full frame after the reset.
        mode = 2'd0;
        s0 = de_tot[0]; s47 = de_tot[47]; a0 = de_al[0]; a47 = de_al[47];
        runFrame(48, -1, 2'd0, -1);
        checkOutput("m0_px0_0", cap[0][0], rgb(8'd0));
        checkOutput("m0_px8_0", cap[0][8], rgb(8'd7));
        checkOutput("m0_px8_6", cap[6][8], rgb(8'd0));
        checkOutput("m0_px16_30", cap[30][16], rgb(8'd3));
        checkOutput("m0_px63_47", cap[47][63], rgb(8'd0));
        checkOutput("m0_de_line0", 32'(de_tot[0] - s0), 64);
        checkOutput("m0_de_line47", 32'(de_tot[47] - s47), 64);
        checkOutput("m0_de_align0", 32'(de_al[0] - a0), 64);
        checkOutput("m0_de_align47", 32'(de_al[47] - a47), 64);

        // Mode 1 checkerboard.
        mode = 2'd1;
        s0 = de_tot[0]; s47 = de_tot[47]; a0 = de_al[0];
        runFrame(48, -1, 2'd0, -1);
        checkOutput("m1_tile0_0", cap[0][0], rgb(8'd0));
        checkOutput("m1_tile1_0", cap[0][8], rgb(8'd1));
        checkOutput("m1_tile1_1", cap[6][8], rgb(8'd0));
        checkOutput("m1_tile2_1", cap[6][16], rgb(8'd1));
        checkOutput("m1_de_line0", 32'(de_tot[0] - s0), 64);
        checkOutput("m1_de_line47", 32'(de_tot[47] - s47), 64);
        checkOutput("m1_de_align0", 32'(de_al[0] - a0), 64);

        // Mode switched to 3 at line 20: this frame stays diagonal.
        mode = 2'd0;
        runFrame(48, 20, 2'd3, -1);
        checkOutput("chg_same_frame_0_8", cap[0][8], rgb(8'd7));
        checkOutput("chg_same_frame_40_8", cap[40][8], rgb(8'd5));
        runFrame(48, -1, 2'd0, -1);
        checkOutput("chg_next_tile3_5", cap[30][24], rgb(8'd3));
        checkOutput("chg_next_tile3_5b", cap[35][31], rgb(8'd3));
        checkOutput("chg_next_tile1_5", cap[30][8], rgb(8'd1));

        // Scroll with a 2-frame divider, mode 2 line 0 shows the offset.
        mode = 2'd2;
        scroll_en = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            runFrame(1, -1, 2'd0, -1);
            checkOutput($sformatf("scroll_f%0d_x0", k), cap[0][0], rgb(8'((k / 2) % 8)));
            checkOutput($sformatf("scroll_f%0d_x63", k), cap[0][63], rgb(8'((k / 2) % 8)));
        end
        scroll_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s0 = de_tot[0];
            runFrame(1, -1, 2'd0, -1);
            checkOutput($sformatf("freeze_f%0d", k), cap[0][5], rgb(8'd7));
            checkOutput($sformatf("freeze_de_f%0d", k), 32'(de_tot[0] - s0), 64);
        end
        scroll_en = 1'b1;
        runFrame(1, -1, 2'd0, -1);
        checkOutput("scroll_resume", cap[0][0], rgb(8'd0));
        scroll_en = 1'b0;

        // 645-pixel line: last tile absorbs the 5 remainder pixels.
        mode = 2'd3;
        wide = 1'b1;
        s0 = dew_tot;
        runFrame(1, -1, 2'd0, -1);
        checkOutput("wide_x0", capw[0], rgb(8'd0));
        checkOutput("wide_x559", capw[559], rgb(8'd6));
        checkOutput("wide_x560", capw[560], rgb(8'd7));
        checkOutput("wide_x644", capw[644], rgb(8'd7));
        checkOutput("wide_de_count", 32'(dew_tot - s0), 645);
        wide = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end
endmodule
